mem_req_arbiter: RTL and testbench

Shares the single AXI-Lite master request port of the PCIe-to-AXI-Lite bridge between `NUM_REQ` CQ request sources, such as one CQ controller per physical function. Arbitration is round-robin. The block limits outstanding reads to `OUTSTANDING_READS` and returns each read response to the requester that issued it, in issue order.

---
 rtl/mem_req_arbiter_pkg.sv | 26 ++
 rtl/mem_req_arbiter_if.sv | 51 +++++
 rtl/mem_req_arbiter_rd_order_fifo.sv | 60 ++++++
 rtl/mem_req_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_req_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// Shared widths, slot encodings and request payload type for the
// PCIe-to-AXI-Lite bridge request path.
package pcie2axil_defs;

    localparam int MEM_REQ_ADDR_W = 49;
    localparam int MEM_REQ_BE_W   = 8;
    localparam int MEM_REQ_DATA_W = 64;
    localparam int BAR_W          = 3;
    localparam int REQ_IDX_W      = 2;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    typedef struct packed {
        logic [BAR_W-1:0]          bar_hit;
        logic [MEM_REQ_ADDR_W-1:0] pcie_address;
        logic [MEM_REQ_BE_W-1:0]   byte_enable;
        logic                      write_readn;
        logic                      phys_func;
        logic [MEM_REQ_DATA_W-1:0] write_data;
        logic [REQ_IDX_W-1:0]      src;
    } mem_req_t;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Request, downstream request and read-return signals of the arbiter.
// master = arbiter side, slave = requesters plus AXI-Lite master side.
interface mem_req_arbiter_if
    import pcie2axil_defs::*;
#(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]                s_req_valid;
    logic [NUM_REQ-1:0]                s_req_ready;
    logic [BAR_W*NUM_REQ-1:0]          s_req_bar_hit;
    logic [MEM_REQ_ADDR_W*NUM_REQ-1:0] s_req_pcie_address;
    logic [MEM_REQ_BE_W*NUM_REQ-1:0]   s_req_byte_enable;
    logic [NUM_REQ-1:0]                s_req_write_readn;
    logic [NUM_REQ-1:0]                s_req_phys_func;
    logic [MEM_REQ_DATA_W*NUM_REQ-1:0] s_req_write_data;

    logic                      m_req_valid;
    logic                      m_req_ready;
    logic [BAR_W-1:0]          m_req_bar_hit;
    logic [MEM_REQ_ADDR_W-1:0] m_req_pcie_address;
    logic [MEM_REQ_BE_W-1:0]   m_req_byte_enable;
    logic                      m_req_write_readn;
    logic                      m_req_phys_func;
    logic [MEM_REQ_DATA_W-1:0] m_req_write_data;
    logic [REQ_IDX_W-1:0]      m_req_src;

    logic                      m_rdata_valid;
    logic                      m_rdata_ready;
    logic [MEM_REQ_DATA_W-1:0] m_rdata;
    logic [NUM_REQ-1:0]        s_rdata_valid;
    logic [NUM_REQ-1:0]        s_rdata_ready;
    logic [MEM_REQ_DATA_W-1:0] s_rdata;

    modport master (
        input  s_req_valid, s_req_bar_hit, s_req_pcie_address, s_req_byte_enable,
               s_req_write_readn, s_req_phys_func, s_req_write_data,
               m_req_ready, m_rdata_valid, m_rdata, s_rdata_ready,
        output s_req_ready, m_req_valid, m_req_bar_hit, m_req_pcie_address,
               m_req_byte_enable, m_req_write_readn, m_req_phys_func,
               m_req_write_data, m_req_src, m_rdata_ready, s_rdata_valid, s_rdata
    );

    modport slave (
        output s_req_valid, s_req_bar_hit, s_req_pcie_address, s_req_byte_enable,
               s_req_write_readn, s_req_phys_func, s_req_write_data,
               m_req_ready, m_rdata_valid, m_rdata, s_rdata_ready,
        input  s_req_ready, m_req_valid, m_req_bar_hit, m_req_pcie_address,
               m_req_byte_enable, m_req_write_readn, m_req_phys_func,
               m_req_write_data, m_req_src, m_rdata_ready, s_rdata_valid, s_rdata
    );
endinterface

// File: rtl/mem_req_arbiter_rd_order_fifo.sv
// Order FIFO holding the requester index of every read in flight;
// depth need not be a power of two.
module rd_order_fifo
    import pcie2axil_defs::*;
#(
    parameter int DEPTH = 5,
    parameter int WIDTH = REQ_IDX_W,
    parameter int CNT_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign do_pop     = pop_i & ~empty_o;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push    = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite request slot between NUM_REQ
// CQ sources, with in-order routing of read responses back to their issuers.
module mem_req_arbiter
    import pcie2axil_defs::*;
#(
    parameter int TCQ               = 1,
    parameter int NUM_REQ           = 2,
    parameter int OUTSTANDING_READS = 5
) (
    input  logic                   axis_clk,
    input  logic                   axis_areset,
    mem_req_arbiter_if.master      bus,
    output logic [2:0]             rd_outstanding,
    output logic                   err_unexpected_rdata
);
    if (NUM_REQ < 2 || NUM_REQ > 4 || OUTSTANDING_READS < 1 ||
        OUTSTANDING_READS > 7 || TCQ < 0) begin : g_bad_params
        $error("mem_req_arbiter: unsupported parameter combination");
    end

    slot_state_e            state_q;
    logic [REQ_IDX_W-1:0]   last_grant_q;
    mem_req_t               payload_q, payload_d;
    logic                   err_q;

    logic                   slot_open;
    logic [NUM_REQ-1:0]     eligible;
    logic                   grant_vld;
    logic [REQ_IDX_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0]     grant;

    logic                   fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [REQ_IDX_W-1:0]   fifo_head;
    logic [2:0]             fifo_count;
    logic [NUM_REQ-1:0]     s_rdata_valid_c;
    logic                   m_rdata_ready_c;

    assign slot_open = (state_q == SLOT_EMPTY) | bus.m_req_ready;

    // Reads need a free FIFO entry as of this cycle; a same-cycle pop does not count.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = ~axis_areset & slot_open & bus.s_req_valid[i] &
                          (bus.s_req_write_readn[i] | ~fifo_full);
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = last_grant_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_vld && eligible[i] &&
                    (i == (int'(last_grant_q) + k) % NUM_REQ)) begin
                    grant_vld = 1'b1;
                    grant_idx = REQ_IDX_W'(i);
                end
            end
        end
    end

    assign grant = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;

    always_comb begin
        payload_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                payload_d.bar_hit      = bus.s_req_bar_hit[i*BAR_W +: BAR_W];
                payload_d.pcie_address = bus.s_req_pcie_address[i*MEM_REQ_ADDR_W +: MEM_REQ_ADDR_W];
                payload_d.byte_enable  = bus.s_req_byte_enable[i*MEM_REQ_BE_W +: MEM_REQ_BE_W];
                payload_d.write_readn  = bus.s_req_write_readn[i];
                payload_d.phys_func    = bus.s_req_phys_func[i];
                payload_d.write_data   = bus.s_req_write_data[i*MEM_REQ_DATA_W +: MEM_REQ_DATA_W];
                payload_d.src          = REQ_IDX_W'(i);
            end
        end
    end

    always_ff @(posedge axis_clk or posedge axis_areset) begin
        if (axis_areset) begin
            state_q      <= SLOT_EMPTY;
            last_grant_q <= REQ_IDX_W'(NUM_REQ - 1);
            payload_q    <= '0;
        end else if (grant_vld) begin
            state_q      <= SLOT_FULL;
            last_grant_q <= grant_idx;
            payload_q    <= payload_d;
        end else if (bus.m_req_ready) begin
            state_q      <= SLOT_EMPTY;
        end
    end

    assign bus.s_req_ready        = grant;
    assign bus.m_req_valid        = (state_q == SLOT_FULL);
    assign bus.m_req_bar_hit      = payload_q.bar_hit;
    assign bus.m_req_pcie_address = payload_q.pcie_address;
    assign bus.m_req_byte_enable  = payload_q.byte_enable;
    assign bus.m_req_write_readn  = payload_q.write_readn;
    assign bus.m_req_phys_func    = payload_q.phys_func;
    assign bus.m_req_write_data   = payload_q.write_data;
    assign bus.m_req_src          = payload_q.src;

    assign fifo_push = grant_vld & ~payload_d.write_readn;
    assign fifo_pop  = bus.m_rdata_valid & m_rdata_ready_c;

    rd_order_fifo #(
        .DEPTH (OUTSTANDING_READS),
        .WIDTH (REQ_IDX_W),
        .CNT_W (3)
    ) u_rd_order_fifo (
        .clk_i       (axis_clk),
        .rst_i       (axis_areset),
        .push_i      (fifo_push),
        .push_data_i (payload_d.src),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    // With nothing outstanding the beat is swallowed so the AXI side never stalls.
    always_comb begin
        s_rdata_valid_c = '0;
        m_rdata_ready_c = 1'b1;
        if (!fifo_empty) begin
            m_rdata_ready_c = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (int'(fifo_head) == i) begin
                    s_rdata_valid_c[i] = bus.m_rdata_valid;
                    m_rdata_ready_c    = bus.s_rdata_ready[i];
                end
            end
        end
    end

    always_ff @(posedge axis_clk or posedge axis_areset) begin
        if (axis_areset) begin
            err_q <= 1'b0;
        end else if (bus.m_rdata_valid && fifo_empty) begin
            err_q <= 1'b1;
        end
    end

    assign bus.s_rdata_valid    = s_rdata_valid_c;
    assign bus.m_rdata_ready    = m_rdata_ready_c;
    assign bus.s_rdata          = bus.m_rdata;
    assign rd_outstanding       = fifo_count;
    assign err_unexpected_rdata = err_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: expected requests and read responses
// are queued by the stimulus and popped by an independent monitor.
module tb_mem_req_arbiter;
    import pcie2axil_defs::*;

    localparam int NR = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rd_outstanding;
    logic       err;

    mem_req_arbiter_if #(.NUM_REQ(NR)) bus();

    mem_req_arbiter #(
        .TCQ               (1),
        .NUM_REQ           (NR),
        .OUTSTANDING_READS (5)
    ) dut (
        .axis_clk             (clk),
        .axis_areset          (rst),
        .bus                  (bus),
        .rd_outstanding       (rd_outstanding),
        .err_unexpected_rdata (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  src;
        logic        wr;
        logic [2:0]  bar;
        logic [7:0]  be;
        logic        pf;
        logic [48:0] addr;
        logic [63:0] data;
    } req_t;

    typedef struct packed {
        logic [1:0]  dst;
        logic [63:0] data;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    req_t mon_req, mon_exp_req;
    rsp_t mon_rsp, mon_exp_rsp;
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic wr,
                           input logic [48:0] addr, input logic [63:0] data);
        bus.s_req_valid[i]              = v;
        bus.s_req_write_readn[i]        = wr;
        bus.s_req_pcie_address[i*49 +: 49] = addr;
        bus.s_req_write_data[i*64 +: 64]   = data;
        bus.s_req_bar_hit[i*3 +: 3]     = 3'(i + 1);
        bus.s_req_byte_enable[i*8 +: 8] = 8'hF0 | 8'(i);
        bus.s_req_phys_func[i]          = i[0];
    endtask

    function automatic req_t exp_req(input int i, input logic wr,
                                     input logic [48:0] addr, input logic [63:0] data);
        req_t r;
        r.src  = 2'(i);
        r.wr   = wr;
        r.bar  = 3'(i + 1);
        r.be   = 8'hF0 | 8'(i);
        r.pf   = i[0];
        r.addr = addr;
        r.data = data;
        return r;
    endfunction

    function automatic rsp_t exp_rsp(input int d, input logic [63:0] data);
        rsp_t r;
        r.dst  = 2'(d);
        r.data = data;
        return r;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted m_req and every delivered read beat is scored.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.m_req_valid && bus.m_req_ready) begin
                mon_req = '{src: bus.m_req_src, wr: bus.m_req_write_readn, bar: bus.m_req_bar_hit,
                            be: bus.m_req_byte_enable, pf: bus.m_req_phys_func,
                            addr: bus.m_req_pcie_address, data: bus.m_req_write_data};
                if (req_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL m_req_extra: got %0h expected no request", mon_req);
                end else begin
                    mon_exp_req = req_q.pop_front();
                    check("m_req", mon_req, mon_exp_req);
                end
            end
            if (bus.m_rdata_ready && (|bus.s_rdata_valid)) begin
                case (bus.s_rdata_valid)
                    2'b01:   mon_rsp.dst = 2'd0;
                    2'b10:   mon_rsp.dst = 2'd1;
                    default: mon_rsp.dst = 2'd3;
                endcase
                mon_rsp.data = bus.s_rdata;
                if (rsp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL s_rdata_extra: got %0h expected no response", mon_rsp);
                end else begin
                    mon_exp_rsp = rsp_q.pop_front();
                    check("s_rdata", mon_rsp, mon_exp_rsp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst               = 1'b1;
        bus.s_req_valid   = '0;
        bus.m_req_ready   = 1'b0;
        bus.m_rdata_valid = 1'b0;
        bus.m_rdata       = '0;
        bus.s_rdata_ready = '0;
        set_req(0, 1'b0, 1'b1, '0, '0);
        set_req(1, 1'b0, 1'b1, '0, '0);
        #12;
        check("rst_m_req_valid", bus.m_req_valid, 0);
        check("rst_payload", {bus.m_req_src, bus.m_req_bar_hit, bus.m_req_byte_enable,
                              bus.m_req_write_readn, bus.m_req_phys_func,
                              bus.m_req_pcie_address, bus.m_req_write_data}, 0);
        check("rst_rd_outstanding", rd_outstanding, 0);
        check("rst_err", err, 0);
        check("rst_s_rdata_valid", bus.s_rdata_valid, 0);
        tick();
        rst = 1'b0;

        // Continuous writes alternate between requesters.
        bus.m_req_ready = 1'b1;
        set_req(0, 1'b1, 1'b1, 49'h100, 64'hA0);
        set_req(1, 1'b1, 1'b1, 49'h200, 64'hB0);
        #1 check("t1_first_ready", bus.s_req_ready, 2'b01);
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) req_q.push_back(exp_req(0, 1'b1, 49'h100, 64'hA0));
            else            req_q.push_back(exp_req(1, 1'b1, 49'h200, 64'hB0));
            tick();
            check("t1_valid_every_cycle", bus.m_req_valid, 1);
        end
        set_req(0, 1'b0, 1'b1, 49'h100, 64'hA0);
        set_req(1, 1'b0, 1'b1, 49'h200, 64'hB0);
        tick();

        // Read held while m_req_ready is low, then accepted with a back-to-back write.
        bus.m_req_ready = 1'b0;
        set_req(1, 1'b1, 1'b0, 49'h1000, 64'h0);
        req_q.push_back(exp_req(1, 1'b0, 49'h1000, 64'h0));
        tick();
        set_req(1, 1'b0, 1'b0, 49'h1FF8, 64'hDEAD);
        set_req(0, 1'b1, 1'b1, 49'h300, 64'hC0);
        for (int k = 0; k < 3; k++) begin
            #1 check("t2_hold", {bus.m_req_valid, bus.m_req_src, bus.m_req_pcie_address,
                                 bus.m_req_write_readn}, {1'b1, 2'd1, 49'h1000, 1'b0});
            check("t2_no_grant", bus.s_req_ready, 0);
            tick();
        end
        bus.m_req_ready = 1'b1;
        req_q.push_back(exp_req(0, 1'b1, 49'h300, 64'hC0));
        #1 check("t2_b2b_grant", bus.s_req_ready, 2'b01);
        tick();
        set_req(0, 1'b0, 1'b1, 49'h300, 64'hC0);
        check("t2_rd_outstanding", rd_outstanding, 1);
        tick();
        bus.s_rdata_ready = 2'b11;
        bus.m_rdata_valid = 1'b1;
        bus.m_rdata       = 64'h1111;
        rsp_q.push_back(exp_rsp(1, 64'h1111));
        tick();
        bus.m_rdata_valid = 1'b0;
        check("t2_drained", rd_outstanding, 0);

        // Outstanding-read limit: a write bypasses the stalled sixth read.
        for (int k = 0; k < 5; k++) begin
            set_req(0, 1'b1, 1'b0, 49'h2000 + 49'(k * 8), 64'h0);
            req_q.push_back(exp_req(0, 1'b0, 49'h2000 + 49'(k * 8), 64'h0));
            tick();
        end
        check("t3_five_outstanding", rd_outstanding, 5);
        set_req(0, 1'b1, 1'b0, 49'h2028, 64'h0);
        set_req(1, 1'b1, 1'b1, 49'h400, 64'hD0);
        #1 check("t3_write_bypasses", bus.s_req_ready, 2'b10);
        req_q.push_back(exp_req(1, 1'b1, 49'h400, 64'hD0));
        tick();
        set_req(1, 1'b0, 1'b1, 49'h400, 64'hD0);
        #1 check("t3_read_stalled", bus.s_req_ready, 0);
        bus.m_rdata_valid = 1'b1;
        bus.m_rdata       = 64'hB0;
        rsp_q.push_back(exp_rsp(0, 64'hB0));
        #1 check("t3_pop_not_same_cycle", bus.s_req_ready, 0);
        tick();
        bus.m_rdata_valid = 1'b0;
        #1 check("t3_sixth_granted", bus.s_req_ready, 2'b01);
        check("t3_after_pop", rd_outstanding, 4);
        req_q.push_back(exp_req(0, 1'b0, 49'h2028, 64'h0));
        tick();
        set_req(0, 1'b0, 1'b0, 49'h2028, 64'h0);
        for (int k = 0; k < 5; k++) begin
            bus.m_rdata_valid = 1'b1;
            bus.m_rdata       = 64'hB1 + 64'(k);
            rsp_q.push_back(exp_rsp(0, 64'hB1 + 64'(k)));
            tick();
        end
        bus.m_rdata_valid = 1'b0;
        check("t3_drained", rd_outstanding, 0);

        // Responses follow issue order 1, 0, 1.
        set_req(1, 1'b1, 1'b0, 49'h3000, 64'h0);
        req_q.push_back(exp_req(1, 1'b0, 49'h3000, 64'h0));
        tick();
        set_req(1, 1'b0, 1'b0, 49'h3000, 64'h0);
        set_req(0, 1'b1, 1'b0, 49'h3008, 64'h0);
        req_q.push_back(exp_req(0, 1'b0, 49'h3008, 64'h0));
        tick();
        set_req(0, 1'b0, 1'b0, 49'h3008, 64'h0);
        set_req(1, 1'b1, 1'b0, 49'h3010, 64'h0);
        req_q.push_back(exp_req(1, 1'b0, 49'h3010, 64'h0));
        tick();
        set_req(1, 1'b0, 1'b0, 49'h3010, 64'h0);
        bus.s_rdata_ready = 2'b01;
        bus.m_rdata_valid = 1'b1;
        bus.m_rdata       = 64'hA;
        #1 check("t4_backpressure", bus.m_rdata_ready, 0);
        check("t4_route_head", bus.s_rdata_valid, 2'b10);
        tick();
        check("t4_no_pop", rd_outstanding, 3);
        bus.s_rdata_ready = 2'b11;
        rsp_q.push_back(exp_rsp(1, 64'hA));
        tick();
        bus.m_rdata = 64'hB;
        rsp_q.push_back(exp_rsp(0, 64'hB));
        tick();
        bus.m_rdata = 64'hC;
        rsp_q.push_back(exp_rsp(1, 64'hC));
        tick();
        bus.m_rdata_valid = 1'b0;
        check("t4_drained", rd_outstanding, 0);

        // Unexpected read data is dropped and flagged.
        bus.m_rdata_valid = 1'b1;
        bus.m_rdata       = 64'hEE;
        #1 check("t5_ready_when_empty", bus.m_rdata_ready, 1);
        check("t5_no_route", bus.s_rdata_valid, 0);
        tick();
        bus.m_rdata_valid = 1'b0;
        check("t5_err_set", err, 1);
        tick(2);
        check("t5_err_sticky", err, 1);

        // Asynchronous reset with reads outstanding and the slot full.
        for (int k = 0; k < 3; k++) begin
            set_req(1, 1'b1, 1'b0, 49'h4000 + 49'(k * 8), 64'h0);
            if (k < 2) req_q.push_back(exp_req(1, 1'b0, 49'h4000 + 49'(k * 8), 64'h0));
            tick();
        end
        bus.m_req_ready = 1'b0;
        set_req(1, 1'b0, 1'b0, 49'h4010, 64'h0);
        check("t6_pre_outstanding", rd_outstanding, 3);
        check("t6_pre_slot_full", bus.m_req_valid, 1);
        set_req(0, 1'b1, 1'b1, 49'h500, 64'hE0);
        #2 rst = 1'b1;
        #1 check("t6_rst_m_req_valid", bus.m_req_valid, 0);
        check("t6_rst_payload", {bus.m_req_src, bus.m_req_bar_hit, bus.m_req_byte_enable,
                                 bus.m_req_write_readn, bus.m_req_phys_func,
                                 bus.m_req_pcie_address, bus.m_req_write_data}, 0);
        check("t6_rst_s_req_ready", bus.s_req_ready, 0);
        check("t6_rst_rd_outstanding", rd_outstanding, 0);
        check("t6_rst_err", err, 0);
        check("t6_rst_s_rdata_valid", bus.s_rdata_valid, 0);
        bus.m_req_ready = 1'b1;
        set_req(1, 1'b1, 1'b1, 49'h600, 64'hF0);
        tick(2);
        rst = 1'b0;
        #1 check("t6_first_grant_req0", bus.s_req_ready, 2'b01);
        req_q.push_back(exp_req(0, 1'b1, 49'h500, 64'hE0));
        tick();
        set_req(0, 1'b0, 1'b1, 49'h500, 64'hE0);
        set_req(1, 1'b0, 1'b1, 49'h600, 64'hF0);
        tick();
        bus.m_rdata_valid = 1'b1;
        bus.m_rdata       = 64'h77;
        tick();
        bus.m_rdata_valid = 1'b0;
        check("t6_stale_rdata_flagged", err, 1);
        tick(2);

        check("req_queue_empty", req_q.size(), 0);
        check("rsp_queue_empty", rsp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
